stream_arb_mux: RTL and testbench
=================================

Name: stream_arb_mux

Overview:
- Registered N-channel stream multiplexer with per-channel valid/ready handshake.
- Arbitration is internal; an external select is no longer used.
- Packet lock keeps a multi-beat transfer on one channel until its last beat.
- Sits between several producer streams and one shared consumer, e.g. a shared bus or a single output FIFO.

Parameters:
- in_bitwidth, 8: data width per channel.
- in_inputs, 4: number of input channels (>=1).
- arb_mode, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- use_lock, 1: 1 = hold grant until a beat with in_last=1; 0 = arbitrate every beat.
- log2ofin, ($clog2(in_inputs) <= 0) ? 1 : $clog2(in_inputs): channel index width, minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_data  input  in_bitwidth*in_inputs  packed channel data; channel i at [i*in_bitwidth +: in_bitwidth].
- in_valid  input  in_inputs  per-channel valid.
- in_last  input  in_inputs  per-channel last-beat flag.
- in_ready  output  in_inputs  per-channel ready (combinational).
- out_data  output  in_bitwidth  registered output data.
- out_sel  output  log2ofin  index of the channel that produced out_data.
- out_last  output  1  registered last flag.
- out_valid  output  1  output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_sel=0, out_last=0, RR pointer=0, lock cleared. in_ready=0 because of the rules below.
- Load enable: load = !out_valid || out_ready.
  - One-entry output register.
  - Full throughput: 1 beat/cycle when out_ready is held high.
- Grant (combinational, one-hot or zero):
  - Unlocked: the highest-priority channel with in_valid=1.
    - Round-robin: search starts at pointer and wraps in_inputs-1 -> 0.
    - Fixed: lowest index wins.
  - Locked: only lock_ch may be granted, and only if in_valid[lock_ch]=1. Other channels are never granted, even if valid.
- in_ready[i] = load && grant[i]. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On transfer from channel g (next edge):
  - out_data <= channel g data; out_sel <= g; out_last <= in_last[g]; out_valid <= 1.
- On load with no transfer: out_valid <= 0.
- With out_valid=1 and out_ready=0: all output registers hold and every in_ready is 0.
- Latency: exactly 1 cycle from input handshake to out_valid.
- RR pointer update: on a transfer with in_last[g]=1, or any transfer when use_lock=0, pointer <= (g==in_inputs-1) ? 0 : g+1. Otherwise unchanged. Ignored when arb_mode=1.
- Lock (use_lock=1):
  - A transfer with in_last[g]=0 sets lock_ch=g, locked=1.
  - A transfer from lock_ch with in_last=1 clears the lock.
  - If the locked channel drops valid mid-packet, no grant is made (bubble) and the lock is held.
- in_inputs=1: out_sel is a 1-bit constant 0; arbitration is trivial.
- Input protocol (bench asserts this): once in_valid[i]=1, in_valid[i], in_data and in_last stay stable until the transfer.
- Reset mid-packet: lock and pointer cleared, out_valid=0; the partial packet is dropped.

Test Plan (in_inputs=4, in_bitwidth=8):
1. Round-robin, use_lock=0, all four channels valid with in_last=1 continuously, out_ready=1 → out_sel sequence 0,1,2,3,0,1; one beat/cycle; first out_valid 1 cycle after the first handshake.
2. Backpressure: beat 0xA5 from ch2 accepted, out_ready=0 for 3 cycles → out_data=0xA5 and out_sel=2 held, in_ready=0000; out_ready=1 → next beat accepted in the same cycle.
3. Lock: ch1 sends 3 beats (last on the 3rd) while ch0/ch3 are valid → output ch1,ch1,ch1 then ch3. Pointer after ch1's last is 2, so ch3 wins over ch0.
4. Locked channel gap: ch0 beat with last=0, then in_valid[0]=0 for 2 cycles while ch2 is valid → out_valid=0 during the gap, in_ready[2]=0; ch0 resumes with last=1 → lock cleared, ch2 served next.
5. Fixed priority (arb_mode=1), ch1 and ch3 continuously valid → ch1 always wins and ch3 is starved; drop ch1 → ch3 served.
6. Assert rst_n=0 asynchronously mid-packet on ch2 → all outputs 0 immediately, no clock needed; after release, ch0 wins with pointer=0.

Source files
------------

// File: rtl/stream_arb_mux.sv
// ---------------------------------------------------------------------------
// stream_arb_mux
//
// Registered N-channel stream multiplexer. Several producer streams compete
// for one consumer; an internal arbiter (round-robin or fixed priority) picks
// one channel per beat. An optional packet lock keeps a multi-beat packet on
// its channel until the beat flagged with in_last.
//
// Handshake: a beat moves on channel i when in_valid[i] && in_ready[i], and
// leaves on the output side when out_valid && out_ready. A producer holds
// in_valid, its data and in_last stable until its beat is taken.
// in_ready is combinational. It depends on in_valid, the output-register
// state and out_ready. It never depends on in_ready itself.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_data   packed channel data, channel i at [i*in_bitwidth +: in_bitwidth]
//   in_valid  per-channel valid
//   in_last   per-channel last-beat flag
//   in_ready  per-channel ready (combinational)
//   out_data  registered output data
//   out_sel   index of the channel that produced out_data
//   out_last  registered last flag
//   out_valid output valid
//   out_ready consumer ready
// ---------------------------------------------------------------------------
module stream_arb_mux #(
  parameter int in_bitwidth = 8,
  parameter int in_inputs   = 4,
  parameter int arb_mode    = 0,
  parameter int use_lock    = 1,
  parameter int log2ofin    = ($clog2(in_inputs) <= 0) ? 1 : $clog2(in_inputs)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [in_bitwidth*in_inputs-1:0] in_data,
  input  logic [in_inputs-1:0]             in_valid,
  input  logic [in_inputs-1:0]             in_last,
  output logic [in_inputs-1:0]             in_ready,
  output logic [in_bitwidth-1:0]           out_data,
  output logic [log2ofin-1:0]              out_sel,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready
);

  // Lock FSM: open = arbitrate freely, locked = only lock_ch may be granted.
  localparam logic [0:0] st_open   = 1'b0;
  localparam logic [0:0] st_locked = 1'b1;

  localparam logic [log2ofin-1:0] last_ch = log2ofin'(in_inputs - 1);

  logic [0:0]             state_q, state_d;
  logic [log2ofin-1:0]    lock_ch_q, lock_ch_d;
  logic [log2ofin-1:0]    ptr_q, ptr_d;
  logic [in_bitwidth-1:0] out_data_q, out_data_d;
  logic [log2ofin-1:0]    out_sel_q, out_sel_d;
  logic                   out_last_q, out_last_d;
  logic                   out_valid_q, out_valid_d;

  logic                   load;
  logic                   xfer;
  logic                   found;
  logic [in_inputs-1:0]   grant;
  logic [log2ofin-1:0]    g_idx;
  logic [in_bitwidth-1:0] g_data;
  logic                   g_last;
  int                     cand;

  // The single output register may be refilled when empty or being drained.
  assign load = !out_valid_q || out_ready;

  // Grant: one-hot or zero. Candidates are visited in priority order
  // (rotating from ptr_q in round-robin mode, from 0 in fixed mode) and the
  // first valid one wins.
  always_comb begin : grant_logic
    grant = '0;
    found = 1'b0;
    cand  = 0;
    if (state_q == st_locked) begin
      // A stalled locked channel produces a bubble rather than a grant
      // elsewhere, so packets never interleave.
      for (int i = 0; i < in_inputs; i++) begin
        if (log2ofin'(i) == lock_ch_q) grant[i] = in_valid[i];
      end
    end else begin
      for (int k = 0; k < in_inputs; k++) begin
        if (arb_mode == 1) begin
          cand = k;
        end else begin
          cand = int'(ptr_q) + k;
          if (cand >= in_inputs) cand = cand - in_inputs;
        end
        for (int i = 0; i < in_inputs; i++) begin
          if (i == cand && !found && in_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
  end

  // Fields of the granted channel.
  always_comb begin : grant_mux
    g_idx  = '0;
    g_data = '0;
    g_last = 1'b0;
    for (int i = 0; i < in_inputs; i++) begin
      if (grant[i]) begin
        g_idx  = log2ofin'(i);
        g_data = in_data[i*in_bitwidth +: in_bitwidth];
        g_last = in_last[i];
      end
    end
  end

  assign xfer     = load && (|grant);
  assign in_ready = grant & {in_inputs{load}};

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    ptr_d       = ptr_q;
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    if (load) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = g_data;
      out_sel_d  = g_idx;
      out_last_d = g_last;
      // The pointer moves past the winner at packet boundaries (every beat
      // when packets are not locked).
      if (arb_mode == 0 && (g_last || use_lock == 0)) begin
        ptr_d = (g_idx == last_ch) ? '0 : g_idx + 1'b1;
      end
      if (use_lock != 0) begin
        if (g_last) begin
          state_d = st_open;
        end else begin
          state_d   = st_locked;
          lock_ch_d = g_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= st_open;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_stream_arb_mux
//
// Three instances with independent input buses:
//   j=0 u_rr : round-robin, packet lock
//   j=1 u_fp : fixed priority, packet lock
//   j=2 u_nl : round-robin, no lock
// A behavioural model per instance is checked every cycle at the falling
// edge; directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_stream_arb_mux;
  localparam int W = 8;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic [N-1:0]   vld [3];
  logic [W*N-1:0] dat [3];
  logic [N-1:0]   lst [3];
  logic           rdy [3];
  logic [N-1:0]   ir  [3];
  logic [W-1:0]   od  [3];
  logic [1:0]     os  [3];
  logic           ol  [3];
  logic           ov  [3];

  int errors = 0;
  int checks = 0;

  stream_arb_mux #(.in_bitwidth(W), .in_inputs(N), .arb_mode(0), .use_lock(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(dat[0]), .in_valid(vld[0]), .in_last(lst[0]),
    .in_ready(ir[0]), .out_data(od[0]), .out_sel(os[0]), .out_last(ol[0]),
    .out_valid(ov[0]), .out_ready(rdy[0]));

  stream_arb_mux #(.in_bitwidth(W), .in_inputs(N), .arb_mode(1), .use_lock(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(dat[1]), .in_valid(vld[1]), .in_last(lst[1]),
    .in_ready(ir[1]), .out_data(od[1]), .out_sel(os[1]), .out_last(ol[1]),
    .out_valid(ov[1]), .out_ready(rdy[1]));

  stream_arb_mux #(.in_bitwidth(W), .in_inputs(N), .arb_mode(0), .use_lock(0)) u_nl (
    .clk(clk), .rst_n(rst_n), .in_data(dat[2]), .in_valid(vld[2]), .in_last(lst[2]),
    .in_ready(ir[2]), .out_data(od[2]), .out_sel(os[2]), .out_last(ol[2]),
    .out_valid(ov[2]), .out_ready(rdy[2]));

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_ptr    [3];
  int           m_lch    [3];
  bit           m_locked [3];
  bit           m_ov     [3];
  logic [W-1:0] m_od     [3];
  int           m_os     [3];
  bit           m_ol     [3];
  // Beats offered but not taken at the last edge; they must still be offered.
  logic [N-1:0]   pv [3];
  logic [W*N-1:0] pd [3];
  logic [N-1:0]   pl [3];

  // Winner for instance j under the current inputs, or -1.
  function automatic int pick(input int j);
    int c;
    if (m_locked[j]) return vld[j][m_lch[j]] ? m_lch[j] : -1;
    for (int k = 0; k < N; k++) begin
      c = (j == 1) ? k : (m_ptr[j] + k) % N;
      if (vld[j][c]) return c;
    end
    return -1;
  endfunction

  initial begin : model
    int           w;
    bit           load;
    logic [N-1:0] exp_ir;
    bit           lin;
    forever begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (!rst_n) begin
          m_ptr[j] = 0; m_lch[j] = 0; m_locked[j] = 0;
          m_ov[j] = 0; m_od[j] = '0; m_os[j] = 0; m_ol[j] = 0;
          pv[j] = '0;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (pv[j][i]) begin
              chk($sformatf("u%0d_hold_valid%0d", j, i), 32'(vld[j][i]), 32'd1);
              chk($sformatf("u%0d_hold_data%0d", j, i), 32'(dat[j][i*W +: W]), 32'(pd[j][i*W +: W]));
              chk($sformatf("u%0d_hold_last%0d", j, i), 32'(lst[j][i]), 32'(pl[j][i]));
            end
          end
        end
        load = !m_ov[j] || rdy[j];
        w = pick(j);
        exp_ir = '0;
        if (load && w >= 0) exp_ir[w] = 1'b1;
        chk($sformatf("u%0d_out_valid", j), 32'(ov[j]), 32'(m_ov[j]));
        if (m_ov[j] || !rst_n) begin
          chk($sformatf("u%0d_out_data", j), 32'(od[j]), 32'(m_od[j]));
          chk($sformatf("u%0d_out_sel", j), 32'(os[j]), 32'(m_os[j]));
          chk($sformatf("u%0d_out_last", j), 32'(ol[j]), 32'(m_ol[j]));
        end
        chk($sformatf("u%0d_in_ready", j), 32'(ir[j]), 32'(exp_ir));
        // Advance to the state after the coming rising edge.
        if (rst_n) begin
          pv[j] = vld[j];
          pd[j] = dat[j];
          pl[j] = lst[j];
          if (load) begin
            m_ov[j] = (w >= 0);
            if (w >= 0) begin
              pv[j][w] = 1'b0;
              lin = lst[j][w];
              m_od[j] = dat[j][w*W +: W];
              m_os[j] = w;
              m_ol[j] = lin;
              if (j != 1 && (lin || j == 2)) m_ptr[j] = (w + 1) % N;
              if (j != 2) begin
                m_locked[j] = !lin;
                m_lch[j] = w;
              end
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_ch(input int j, input int ch, input logic v, input logic [7:0] d, input logic l);
    vld[j][ch] = v;
    dat[j][ch*W +: W] = d;
    lst[j][ch] = l;
  endtask

  task automatic clear_inputs();
    for (int j = 0; j < 3; j++) begin
      vld[j] = '0;
      dat[j] = '0;
      lst[j] = '0;
      rdy[j] = 1'b1;
    end
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_ready(input int j, input string tag, input logic [3:0] r);
    chk($sformatf("%s_in_ready", tag), 32'(ir[j]), 32'(r));
  endtask

  task automatic chk_idle(input int j, input string tag);
    chk($sformatf("%s_out_valid", tag), 32'(ov[j]), 32'd0);
  endtask

  task automatic chk_beat(input int j, input string tag, input int s, input logic [7:0] d, input logic l);
    chk($sformatf("%s_out_valid", tag), 32'(ov[j]), 32'd1);
    chk($sformatf("%s_out_sel", tag), 32'(os[j]), 32'(s));
    chk($sformatf("%s_out_data", tag), 32'(od[j]), 32'(d));
    chk($sformatf("%s_out_last", tag), 32'(ol[j]), 32'(l));
  endtask

  // ---------------- directed scenarios ----------------
  int seq1 [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    #2;

    // Reset values on every instance.
    do_reset();
    neg();
    for (int j = 0; j < 3; j++) begin
      chk_idle(j, $sformatf("rst_u%0d", j));
      chk($sformatf("rst_u%0d_data", j), 32'(od[j]), 32'd0);
      chk($sformatf("rst_u%0d_sel", j), 32'(os[j]), 32'd0);
      chk($sformatf("rst_u%0d_last", j), 32'(ol[j]), 32'd0);
      chk_ready(j, $sformatf("rst_u%0d", j), 4'b0000);
    end

    // 1: round-robin, all channels valid single-beat packets.
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_ch(0, i, 1'b1, 8'(8'h10 + i), 1'b1);
      set_ch(2, i, 1'b1, 8'(8'h10 + i), 1'b1);
    end
    neg();
    chk_idle(0, "rr_first"); chk_ready(0, "rr_first", 4'b0001);
    chk_idle(2, "nl_first"); chk_ready(2, "nl_first", 4'b0001);
    for (int c = 0; c < 6; c++) begin
      tick();
      neg();
      chk_beat(0, $sformatf("rr_seq%0d", c), seq1[c], 8'(8'h10 + seq1[c]), 1'b1);
      chk_beat(2, $sformatf("nl_seq%0d", c), seq1[c], 8'(8'h10 + seq1[c]), 1'b1);
    end

    // 2: backpressure holds the output register.
    do_reset();
    set_ch(0, 2, 1'b1, 8'hA5, 1'b1);
    neg(); chk_ready(0, "bp_offer", 4'b0100);
    tick();
    set_ch(0, 2, 1'b1, 8'h5A, 1'b1);
    rdy[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      neg();
      chk_beat(0, $sformatf("bp_hold%0d", c), 2, 8'hA5, 1'b1);
      chk_ready(0, $sformatf("bp_hold%0d", c), 4'b0000);
      tick();
    end
    rdy[0] = 1'b1;
    neg(); chk_ready(0, "bp_release", 4'b0100);
    tick();
    set_ch(0, 2, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(0, "bp_next", 2, 8'h5A, 1'b1);
    tick();
    neg(); chk_idle(0, "bp_drain");

    // 3: packet lock on ch1 while ch0/ch3 wait.
    do_reset();
    set_ch(0, 1, 1'b1, 8'h11, 1'b0);
    neg(); chk_ready(0, "lk_start", 4'b0010);
    tick();
    set_ch(0, 1, 1'b1, 8'h12, 1'b0);
    set_ch(0, 0, 1'b1, 8'hC0, 1'b1);
    set_ch(0, 3, 1'b1, 8'hF3, 1'b1);
    neg(); chk_beat(0, "lk_b0", 1, 8'h11, 1'b0); chk_ready(0, "lk_b0", 4'b0010);
    tick();
    set_ch(0, 1, 1'b1, 8'h13, 1'b1);
    neg(); chk_beat(0, "lk_b1", 1, 8'h12, 1'b0); chk_ready(0, "lk_b1", 4'b0010);
    tick();
    set_ch(0, 1, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(0, "lk_b2", 1, 8'h13, 1'b1); chk_ready(0, "lk_b2", 4'b1000);
    tick();
    set_ch(0, 3, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(0, "lk_ch3", 3, 8'hF3, 1'b1); chk_ready(0, "lk_ch3", 4'b0001);
    tick();
    set_ch(0, 0, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(0, "lk_ch0", 0, 8'hC0, 1'b1);

    // 4: locked channel goes idle mid-packet.
    do_reset();
    set_ch(0, 0, 1'b1, 8'h01, 1'b0);
    set_ch(0, 2, 1'b1, 8'h22, 1'b1);
    neg(); chk_ready(0, "gap_start", 4'b0001);
    tick();
    set_ch(0, 0, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(0, "gap_b0", 0, 8'h01, 1'b0); chk_ready(0, "gap_b0", 4'b0000);
    tick();
    neg(); chk_idle(0, "gap_c1"); chk_ready(0, "gap_c1", 4'b0000);
    tick();
    set_ch(0, 0, 1'b1, 8'h02, 1'b1);
    neg(); chk_idle(0, "gap_c2"); chk_ready(0, "gap_c2", 4'b0001);
    tick();
    set_ch(0, 0, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(0, "gap_b1", 0, 8'h02, 1'b1); chk_ready(0, "gap_b1", 4'b0100);
    tick();
    set_ch(0, 2, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(0, "gap_ch2", 2, 8'h22, 1'b1);

    // 5: fixed priority starves ch3 until ch1 stops.
    do_reset();
    set_ch(1, 1, 1'b1, 8'hB1, 1'b1);
    set_ch(1, 3, 1'b1, 8'hD3, 1'b1);
    neg(); chk_ready(1, "fp_start", 4'b0010);
    for (int c = 0; c < 4; c++) begin
      tick();
      neg();
      chk_beat(1, $sformatf("fp_ch1_%0d", c), 1, 8'hB1, 1'b1);
      chk_ready(1, $sformatf("fp_ch1_%0d", c), 4'b0010);
    end
    tick();
    set_ch(1, 1, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(1, "fp_last1", 1, 8'hB1, 1'b1); chk_ready(1, "fp_last1", 4'b1000);
    tick();
    neg(); chk_beat(1, "fp_ch3", 3, 8'hD3, 1'b1);

    // 7: without lock the pointer moves on every beat.
    do_reset();
    set_ch(2, 1, 1'b1, 8'h71, 1'b0);
    set_ch(2, 2, 1'b1, 8'h72, 1'b1);
    neg(); chk_ready(2, "nl_start", 4'b0010);
    tick();
    set_ch(2, 1, 1'b1, 8'h74, 1'b1);
    neg(); chk_beat(2, "nl_b0", 1, 8'h71, 1'b0); chk_ready(2, "nl_b0", 4'b0100);
    tick();
    set_ch(2, 2, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(2, "nl_ch2", 2, 8'h72, 1'b1); chk_ready(2, "nl_ch2", 4'b0010);
    tick();
    set_ch(2, 1, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(2, "nl_b1", 1, 8'h74, 1'b1);

    // 6: asynchronous reset in the middle of a ch2 packet.
    do_reset();
    set_ch(0, 1, 1'b1, 8'h31, 1'b1);
    neg(); chk_ready(0, "ar_pre", 4'b0010);
    tick();
    set_ch(0, 1, 1'b0, 8'h00, 1'b0);
    set_ch(0, 2, 1'b1, 8'h2A, 1'b0);
    neg(); chk_beat(0, "ar_ch1", 1, 8'h31, 1'b1); chk_ready(0, "ar_ch1", 4'b0100);
    tick();
    set_ch(0, 2, 1'b1, 8'h2B, 1'b0);
    neg(); chk_beat(0, "ar_p0", 2, 8'h2A, 1'b0); chk_ready(0, "ar_p0", 4'b0100);
    tick();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("ar_now_out_valid", 32'(ov[0]), 32'd0);
    chk("ar_now_out_data", 32'(od[0]), 32'd0);
    chk("ar_now_out_sel", 32'(os[0]), 32'd0);
    chk("ar_now_out_last", 32'(ol[0]), 32'd0);
    chk("ar_now_in_ready", 32'(ir[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_ch(0, 0, 1'b1, 8'h0E, 1'b1);
    set_ch(0, 2, 1'b1, 8'h2C, 1'b1);
    neg(); chk_idle(0, "ar_after"); chk_ready(0, "ar_after", 4'b0001);
    tick();
    set_ch(0, 0, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(0, "ar_ch0", 0, 8'h0E, 1'b1); chk_ready(0, "ar_ch0", 4'b0100);
    tick();
    set_ch(0, 2, 1'b0, 8'h00, 1'b0);
    neg(); chk_beat(0, "ar_ch2", 2, 8'h2C, 1'b1);

    // ---------------- final report ----------------
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
